// File: rtl/tqvp_hx2003_pulse_tx_scheduler.sv
// tqvp_hx2003_pulse_tx_scheduler: job FIFO sequencing the pulse transmitter through launch, run and inter-job gap
module tqvp_hx2003_pulse_tx_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [31:0]            push_job,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic                   abort,
  output logic [31:0]            tx_config,
  output logic                   tx_run,
  input  logic                   tx_done,
  output logic                   job_done,
  output logic [7:0]             jobs_completed,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [1:0]             state,
  output logic                   all_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, GAP} state_t;
  state_t               state_q, state_d;
  logic [31:0]          cfg_q, cfg_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;
  logic [7:0]           jobs_q, jobs_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          mem_d [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 push, pop;
  assign push_ready     = (cnt_q < CW'(DEPTH)) && !abort;
  assign push           = push_valid && push_ready;
  assign tx_config      = cfg_q;
  assign tx_run         = run_q;
  assign job_done       = done_q;
  assign jobs_completed = jobs_q;
  assign fifo_count     = cnt_q;
  assign state          = state_q;
  assign all_idle       = (state_q == IDLE) && (cnt_q == '0);
  // Job sequencing: abort overrides everything, tx_done only counts while running
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    jobs_d  = jobs_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (cnt_q != '0) begin
          pop     = 1'b1;
          cfg_d   = mem_q[rptr_q];
          state_d = LAUNCH;
        end
        LAUNCH: state_d = RUN;
        RUN: if (tx_done) begin
          done_d  = 1'b1;
          jobs_d  = jobs_q + 8'd1;
          gap_d   = gap_cycles;
          state_d = (gap_cycles != '0) ? GAP : IDLE;
        end
        GAP: begin
          gap_d   = gap_q - GAP_WIDTH'(1);
          state_d = (gap_q <= GAP_WIDTH'(1)) ? IDLE : GAP;
        end
        default: state_d = IDLE;
      endcase
    end
    run_d = (state_d == RUN);
  end
  // Job FIFO: abort flushes, a simultaneous push and pop keep the count
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (abort) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = push_job;
        wptr_d        = wptr_q + AW'(1);
      end
      rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      jobs_q  <= '0;
      gap_q   <= '0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      run_q   <= run_d;
      done_q  <= done_d;
      jobs_q  <= jobs_d;
      gap_q   <= gap_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv
// tb_tqvp_hx2003_pulse_tx_scheduler: scoreboard bench for the pulse transmitter job scheduler
module tb_tqvp_hx2003_pulse_tx_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_job = '0;
  logic [15:0] gap_cycles = '0;
  logic        abort = 1'b0;
  logic [31:0] tx_config;
  logic        tx_run;
  logic        tx_done = 1'b0;
  logic        job_done;
  logic [7:0]  jobs_completed;
  logic [2:0]  fifo_count;
  logic [1:0]  state;
  logic        all_idle;
  logic [31:0] sb [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          exp_jobs = 0;
  tqvp_hx2003_pulse_tx_scheduler #(.DEPTH(4), .GAP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_job(push_job), .gap_cycles(gap_cycles), .abort(abort),
    .tx_config(tx_config), .tx_run(tx_run), .tx_done(tx_done),
    .job_done(job_done), .jobs_completed(jobs_completed),
    .fifo_count(fifo_count), .state(state), .all_idle(all_idle)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] j, input logic exp_acc);
    push_valid = 1'b1;
    push_job = j;
    #1;
    total_cnt++;
    if (push_ready !== exp_acc) $display("FAIL push_ready job=%h got %b exp %b", j, push_ready, exp_acc);
    else pass_cnt++;
    if (exp_acc) sb.push_back(j);
    tick();
    push_valid = 1'b0;
  endtask
  task automatic wait_run(input string tag);
    logic [31:0] exp;
    int n = 0;
    while (tx_run !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (tx_run !== 1'b1) $display("FAIL %s_run_timeout tx_run got %b exp 1", tag, tx_run);
    else if (sb.size() == 0) $display("FAIL %s_sb_empty tx_config got %h exp none", tag, tx_config);
    else begin
      exp = sb.pop_front();
      if (tx_config !== exp) $display("FAIL %s_config got %h exp %h", tag, tx_config, exp);
      else pass_cnt++;
    end
  endtask
  task automatic done_pulse(input string tag, input logic [1:0] exp_state);
    logic [7:0] ej;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    exp_jobs++;
    ej = exp_jobs[7:0];
    total_cnt++;
    if ({job_done, tx_run, jobs_completed, state} !== {1'b1, 1'b0, ej, exp_state})
      $display("FAIL %s_done {done,run,jobs,state} got %b,%b,%0d,%0d exp 1,0,%0d,%0d", tag, job_done, tx_run, jobs_completed, state, ej, exp_state);
    else pass_cnt++;
  endtask
  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b0;
    total_cnt++;
    if ({state, fifo_count, tx_config, tx_run, job_done, jobs_completed, push_ready, all_idle} !== {2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1})
      $display("FAIL reset_values st=%0d cnt=%0d cfg=%h run=%b done=%b jobs=%0d rdy=%b idle=%b exp 0,0,0,0,0,0,1,1", state, fifo_count, tx_config, tx_run, job_done, jobs_completed, push_ready, all_idle);
    else pass_cnt++;
  endtask
  task automatic test_single_job();
    gap_cycles = 16'd5;
    push(32'h0003_0700, 1'b1);
    total_cnt++;
    if ({state, fifo_count} !== {2'd0, 3'd1}) $display("FAIL single_e0 st,cnt got %0d,%0d exp 0,1", state, fifo_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, tx_run, fifo_count, tx_config} !== {2'd1, 1'b0, 3'd0, 32'h0003_0700})
      $display("FAIL single_e1 st,run,cnt,cfg got %0d,%b,%0d,%h exp 1,0,0,00030700", state, tx_run, fifo_count, tx_config);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, tx_run} !== {2'd2, 1'b1}) $display("FAIL single_e2 st,run got %0d,%b exp 2,1", state, tx_run);
    else pass_cnt++;
    wait_run("single");
    tick();
    tick();
    done_pulse("single", 2'd3);
    for (int i = 1; i <= 5; i++) begin
      tick();
      total_cnt++;
      if ({state, job_done} !== {(i < 5) ? 2'd3 : 2'd0, 1'b0})
        $display("FAIL single_gap%0d st,done got %0d,%b exp %0d,0", i, state, job_done, (i < 5) ? 3 : 0);
      else pass_cnt++;
    end
  endtask
  task automatic test_back_to_back();
    gap_cycles = 16'd0;
    push(32'h0102_0304, 1'b1);
    push(32'h8A05_1122, 1'b1);
    push(32'h7F7F_7F7F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_run("b2b");
      done_pulse("b2b", 2'd0);
      if (i < 2) begin
        tick();
        total_cnt++;
        if (state !== 2'd1) $display("FAIL b2b_launch%0d state got %0d exp 1", i, state);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (tx_run !== 1'b1) $display("FAIL b2b_rise%0d tx_run got %b exp 1", i, tx_run);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({all_idle, jobs_completed} !== {1'b1, 8'(exp_jobs)})
      $display("FAIL b2b_end idle,jobs got %b,%0d exp 1,%0d", all_idle, jobs_completed, exp_jobs);
    else pass_cnt++;
  endtask
  task automatic test_fifo_full();
    gap_cycles = 16'd0;
    push(32'h0000_0010, 1'b1);
    wait_run("full_j0");
    for (int i = 1; i <= 4; i++) push(32'h0000_0010 + 32'(i), 1'b1);
    total_cnt++;
    if ({fifo_count, push_ready} !== {3'd4, 1'b0}) $display("FAIL full_count cnt,rdy got %0d,%b exp 4,0", fifo_count, push_ready);
    else pass_cnt++;
    push(32'h0000_0015, 1'b0);
    total_cnt++;
    if ({fifo_count, state} !== {3'd4, 2'd2}) $display("FAIL full_drop cnt,st got %0d,%0d exp 4,2", fifo_count, state);
    else pass_cnt++;
    done_pulse("full_j0", 2'd0);
    tick();
    total_cnt++;
    if ({fifo_count, state} !== {3'd3, 2'd1}) $display("FAIL full_pop cnt,st got %0d,%0d exp 3,1", fifo_count, state);
    else pass_cnt++;
    wait_run("full_j1");
    done_pulse("full_j1", 2'd0);
    wait_run("full_j2");
    done_pulse("full_j2", 2'd0);
    push(32'h0000_0016, 1'b1);
    total_cnt++;
    if ({fifo_count, state} !== {3'd2, 2'd1}) $display("FAIL full_pushpop cnt,st got %0d,%0d exp 2,1", fifo_count, state);
    else pass_cnt++;
    repeat (3) begin
      wait_run("full_drain");
      done_pulse("full_drain", 2'd0);
    end
  endtask
  task automatic test_spurious_done();
    gap_cycles = 16'd3;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total_cnt++;
    if ({state, job_done, jobs_completed} !== {2'd0, 1'b0, 8'(exp_jobs)})
      $display("FAIL spur_idle st,done,jobs got %0d,%b,%0d exp 0,0,%0d", state, job_done, jobs_completed, exp_jobs);
    else pass_cnt++;
    push(32'h0042_2A05, 1'b1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total_cnt++;
    if ({state, job_done, jobs_completed} !== {2'd2, 1'b0, 8'(exp_jobs)})
      $display("FAIL spur_launch st,done,jobs got %0d,%b,%0d exp 2,0,%0d", state, job_done, jobs_completed, exp_jobs);
    else pass_cnt++;
    wait_run("spur");
    done_pulse("spur", 2'd3);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    total_cnt++;
    if ({state, job_done, jobs_completed} !== {2'd3, 1'b0, 8'(exp_jobs)})
      $display("FAIL spur_gap st,done,jobs got %0d,%b,%0d exp 3,0,%0d", state, job_done, jobs_completed, exp_jobs);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (state !== 2'd0) $display("FAIL spur_gap_end state got %0d exp 0", state);
    else pass_cnt++;
  endtask
  task automatic test_abort();
    gap_cycles = 16'd0;
    push(32'h0001_0203, 1'b1);
    push(32'h0004_0506, 1'b1);
    push(32'h0007_0809, 1'b1);
    push(32'h000A_0B0C, 1'b1);
    wait_run("abort_w");
    total_cnt++;
    if (fifo_count !== 3'd3) $display("FAIL abort_queued fifo_count got %0d exp 3", fifo_count);
    else pass_cnt++;
    abort = 1'b1;
    tx_done = 1'b1;
    push_valid = 1'b1;
    push_job = 32'hDEAD_BEEF;
    #1;
    total_cnt++;
    if (push_ready !== 1'b0) $display("FAIL abort_ready push_ready got %b exp 0", push_ready);
    else pass_cnt++;
    tick();
    abort = 1'b0;
    tx_done = 1'b0;
    push_valid = 1'b0;
    sb.delete();
    total_cnt++;
    if ({tx_run, state, fifo_count, job_done, jobs_completed} !== {1'b0, 2'd0, 3'd0, 1'b0, 8'(exp_jobs)})
      $display("FAIL abort_flush run,st,cnt,done,jobs got %b,%0d,%0d,%b,%0d exp 0,0,0,0,%0d", tx_run, state, fifo_count, job_done, jobs_completed, exp_jobs);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, all_idle} !== {2'd0, 1'b1}) $display("FAIL abort_after st,idle got %0d,%b exp 0,1", state, all_idle);
    else pass_cnt++;
  endtask
  task automatic test_async_reset();
    gap_cycles = 16'd10;
    push(32'h0055_3311, 1'b1);
    wait_run("areset_r");
    done_pulse("areset_r", 2'd3);
    push(32'h0066_4422, 1'b1);
    tick();
    total_cnt++;
    if ({state, fifo_count} !== {2'd3, 3'd1}) $display("FAIL areset_pre st,cnt got %0d,%0d exp 3,1", state, fifo_count);
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({state, fifo_count, tx_config, tx_run, job_done, jobs_completed, all_idle} !== {2'd0, 3'd0, 32'd0, 1'b0, 1'b0, 8'd0, 1'b1})
      $display("FAIL areset_values st=%0d cnt=%0d cfg=%h run=%b done=%b jobs=%0d idle=%b exp 0,0,0,0,0,0,1", state, fifo_count, tx_config, tx_run, job_done, jobs_completed, all_idle);
    else pass_cnt++;
    sb.delete();
    exp_jobs = 0;
    tick();
    rst = 1'b0;
    push(32'h0011_2233, 1'b1);
    tick();
    total_cnt++;
    if (state !== 2'd1) $display("FAIL areset_launch state got %0d exp 1", state);
    else pass_cnt++;
    wait_run("areset_t");
    done_pulse("areset_t", 2'd3);
  endtask
  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_fifo_full();
    test_spurious_done();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
